// File: rtl/me_block_sequencer.sv
// Sequences the motion-estimator core over a run of reference blocks, captures each
// block's result into a small first-word-fall-through FIFO and tracks the run minimum.
module me_block_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic [IDX_W-1:0] num_blocks,
    output logic             me_start,
    input  logic             me_completed,
    input  logic [7:0]       me_best_dist,
    input  logic [3:0]       me_motion_x,
    input  logic [3:0]       me_motion_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W+16:0] res_data,
    output logic             busy,
    output logic             run_done,
    output logic [7:0]       run_min_dist,
    output logic [IDX_W-1:0] run_min_idx
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned DATA_W = IDX_W + 17;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StNext
    } state_e;

    state_e             r_state;
    logic [IDX_W-1:0]   r_num;
    logic [IDX_W-1:0]   r_idx;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_comp_prev;
    logic               r_me_start;
    logic               r_run_done;
    logic [7:0]         r_min_dist;
    logic [IDX_W-1:0]   r_min_idx;

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_edge;
    logic               w_tmo_hit;
    logic               w_has_space;
    logic               w_last;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;
    logic [DATA_W-1:0]  w_push_data;

    // Completion edge, timeout, FIFO push/pop decode and the entry to be written.
    always_comb begin
        w_edge      = me_completed && !r_comp_prev;
        w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT - 1));
        w_has_space = (r_count < CNT_W'(FIFO_DEPTH));
        w_last      = (r_idx == (r_num - IDX_W'(1)));
        w_valid     = (r_count != '0);
        w_pop       = w_valid && res_ready;
        w_push      = (r_state == StWait) && (w_edge || w_tmo_hit);
        // A real completion wins over a timeout landing in the same cycle.
        if (w_edge) begin
            w_push_data = {1'b0, r_idx, me_best_dist, me_motion_x, me_motion_y};
        end else begin
            w_push_data = {1'b1, r_idx, 8'hFF, 4'h0, 4'h0};
        end
    end

    // Previous completion level, so only a fresh rising edge counts as done.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_comp_prev <= 1'b0;
        end else begin
            r_comp_prev <= me_completed;
        end
    end

    // Result FIFO storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_push_data;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Run control FSM with registered start/done pulses and run-minimum tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_num      <= '0;
            r_idx      <= '0;
            r_tmo      <= '0;
            r_me_start <= 1'b0;
            r_run_done <= 1'b0;
            r_min_dist <= 8'hFF;
            r_min_idx  <= '0;
        end else begin
            r_me_start <= 1'b0;
            r_run_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (go) begin
                        if (num_blocks != '0) begin
                            r_num      <= num_blocks;
                            r_idx      <= '0;
                            r_min_dist <= 8'hFF;
                            r_min_idx  <= '0;
                            r_state    <= StLaunch;
                        end else begin
                            r_run_done <= 1'b1;
                        end
                    end
                end
                StLaunch: begin
                    // Only one block is ever outstanding, so one free slot is enough.
                    if (w_has_space) begin
                        r_me_start <= 1'b1;
                        r_tmo      <= '0;
                        r_state    <= StWait;
                    end
                end
                StWait: begin
                    if (w_edge) begin
                        if (me_best_dist < r_min_dist) begin
                            r_min_dist <= me_best_dist;
                            r_min_idx  <= r_idx;
                        end
                        r_state <= StNext;
                    end else if (w_tmo_hit) begin
                        r_state <= StNext;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                StNext: begin
                    if (w_last) begin
                        r_run_done <= 1'b1;
                        r_state    <= StIdle;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= StLaunch;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign me_start     = r_me_start;
    assign run_done     = r_run_done;
    assign busy         = (r_state != StIdle);
    assign res_valid    = w_valid;
    assign res_data     = r_mem[r_rptr];
    assign run_min_dist = r_min_dist;
    assign run_min_idx  = r_min_idx;

endmodule

// File: tb/tb_me_block_sequencer.sv
// Bench for me_block_sequencer: behavioural ME core, result monitor and per-scenario tests.
module tb_me_block_sequencer;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned IDX_W      = 8;
    localparam int unsigned TIMEOUT    = 1023;
    localparam int unsigned DW         = IDX_W + 17;

    logic             clock = 1'b0;
    logic             reset;
    logic             go;
    logic [IDX_W-1:0] num_blocks;
    logic             me_start;
    logic             me_completed;
    logic [7:0]       me_best_dist;
    logic [3:0]       me_motion_x;
    logic [3:0]       me_motion_y;
    logic             res_valid;
    logic             res_ready;
    logic [DW-1:0]    res_data;
    logic             busy;
    logic             run_done;
    logic [7:0]       run_min_dist;
    logic [IDX_W-1:0] run_min_idx;

    me_block_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .IDX_W      (IDX_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .go           (go),
        .num_blocks   (num_blocks),
        .me_start     (me_start),
        .me_completed (me_completed),
        .me_best_dist (me_best_dist),
        .me_motion_x  (me_motion_x),
        .me_motion_y  (me_motion_y),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .busy         (busy),
        .run_done     (run_done),
        .run_min_dist (run_min_dist),
        .run_min_idx  (run_min_idx)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // ME core model knobs: completion stays high m_hold cycles after start, then low for
    // m_delay cycles, then rises with the block's result. Block m_never never completes.
    int         m_hold  = 1;
    int         m_delay = 4;
    int         m_never = -1;
    int         m_blk   = 0;
    logic [7:0] m_dist [16];
    logic [3:0] m_x    [16];
    logic [3:0] m_y    [16];

    // Monitor state.
    int            cyc = 0;
    int            n_starts, n_done, busy_seen, min_gap, last_start, unstable;
    int            start_cyc [$];
    int            pop_cyc   [$];
    logic [DW-1:0] got_q     [$];
    bit            rand_ready = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data;

    // Reference results.
    logic [DW-1:0]    exp_q [$];
    logic [7:0]       exp_min;
    logic [IDX_W-1:0] exp_min_idx;

    initial begin
        int blk;
        me_completed = 1'b0;
        me_best_dist = '0;
        me_motion_x  = '0;
        me_motion_y  = '0;
        forever begin
            @(negedge clock);
            if (me_start && !reset) begin
                blk = m_blk;
                m_blk++;
                repeat ((m_hold > 0) ? m_hold : 1) @(posedge clock);
                #1 me_completed = 1'b0;
                if (blk != m_never) begin
                    repeat (m_delay) @(posedge clock);
                    #1;
                    me_best_dist = m_dist[blk];
                    me_motion_x  = m_x[blk];
                    me_motion_y  = m_y[blk];
                    me_completed = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_ready) res_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (me_start) begin
                n_starts++;
                start_cyc.push_back(cyc);
                if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
                last_start = cyc;
            end
            if (run_done) n_done++;
            if (busy) busy_seen++;
            if (prev_stall && res_valid && res_data !== prev_data) unstable++;
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            if (res_valid && res_ready) begin
                got_q.push_back(res_data);
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_stats();
        n_starts   = 0;
        n_done     = 0;
        busy_seen  = 0;
        min_gap    = 1000000;
        last_start = -1;
        unstable   = 0;
        start_cyc.delete();
        pop_cyc.delete();
        got_q.delete();
        m_blk = 0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            m_dist[i] = 8'($urandom_range(0, 255));
            m_x[i]    = 4'($urandom_range(0, 15));
            m_y[i]    = 4'($urandom_range(0, 15));
        end
    endtask

    // Expected FIFO entries and run minimum straight from the block rules.
    task automatic build_exp(input int n);
        exp_q.delete();
        exp_min     = 8'hFF;
        exp_min_idx = '0;
        for (int i = 0; i < n; i++) begin
            if (i == m_never) begin
                exp_q.push_back({1'b1, IDX_W'(i), 8'hFF, 4'h0, 4'h0});
            end else begin
                exp_q.push_back({1'b0, IDX_W'(i), m_dist[i], m_x[i], m_y[i]});
                if (m_dist[i] < exp_min) begin
                    exp_min     = m_dist[i];
                    exp_min_idx = IDX_W'(i);
                end
            end
        end
    endtask

    task automatic do_run(input int n, input int spurious_at, output bit ok);
        clear_stats();
        @(posedge clock);
        #1;
        num_blocks = IDX_W'(n);
        go         = 1'b1;
        @(posedge clock);
        #1;
        go = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (c == spurious_at) begin
                go         = 1'b1;
                num_blocks = IDX_W'(n + 3);
            end else begin
                go = 1'b0;
            end
            @(posedge clock);
            #1;
            if (!busy && !res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        go = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        go         = 1'b0;
        num_blocks = '0;
        res_ready  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({me_start, res_valid, busy, run_done} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {me_start, res_valid, busy, run_done});
        end
        n_checks++;
        if (run_min_dist !== 8'hFF) begin
            n_errors++;
            $display("FAIL reset_min_dist: got %h want ff", run_min_dist);
        end
        n_checks++;
        if (run_min_idx !== '0 || res_data !== '0) begin
            n_errors++;
            $display("FAIL reset_idx_data: got %h/%h want 0/0", run_min_idx, res_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        logic [DW-1:0] g;
        m_hold  = 1;
        m_delay = 19;
        fill_random(3);
        m_dist[0] = 8'd40;
        m_dist[1] = 8'd12;
        m_dist[2] = 8'd12;
        res_ready = 1'b1;
        do_run(3, -1, ok);
        build_exp(3);
        n_checks++;
        if (!ok || got_q.size() != 3) begin
            n_errors++;
            $display("FAIL basic_count: got %0d entries ok=%0d want 3", got_q.size(), ok);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_errors++;
                $display("FAIL basic_entry%0d: got %h want %h", i, g, exp_q[i]);
            end
        end
        n_checks++;
        if (run_min_dist !== 8'd12 || run_min_idx !== IDX_W'(1)) begin
            n_errors++;
            $display("FAIL basic_min: got %0d@%0d want 12@1", run_min_dist, run_min_idx);
        end
        n_checks++;
        if (n_done != 1 || n_starts != 3) begin
            n_errors++;
            $display("FAIL basic_pulses: got done=%0d starts=%0d want 1/3", n_done, n_starts);
        end
        n_checks++;
        if (pop_cyc.size() < 1 || start_cyc.size() < 1 || pop_cyc[0] - start_cyc[0] != 21) begin
            n_errors++;
            $display("FAIL basic_latency: got pops=%0d want entry 21 cycles after start",
                     pop_cyc.size());
        end
    endtask

    task automatic test_stale_completed();
        bit ok;
        logic [DW-1:0] g;
        m_hold  = 5;
        m_delay = 6;
        m_dist[0] = 8'd7;
        m_dist[1] = 8'd9;
        m_x[0] = 4'd1; m_x[1] = 4'd2;
        m_y[0] = 4'd3; m_y[1] = 4'd4;
        res_ready = 1'b1;
        do_run(2, -1, ok);
        build_exp(2);
        n_checks++;
        if (!ok || got_q.size() != 2) begin
            n_errors++;
            $display("FAIL stale_count: got %0d entries ok=%0d want 2", got_q.size(), ok);
        end
        for (int i = 0; i < 2; i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_errors++;
                $display("FAIL stale_entry%0d: got %h want %h", i, g, exp_q[i]);
            end
            n_checks++;
            if (i >= pop_cyc.size() || i >= start_cyc.size() ||
                pop_cyc[i] - start_cyc[i] != m_hold + m_delay + 1) begin
                n_errors++;
                $display("FAIL stale_latency%0d: got no entry at start+%0d", i,
                         m_hold + m_delay + 1);
            end
        end
        m_hold = 1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [DW-1:0] g;
        m_hold  = 1;
        m_delay = 1;
        fill_random(4);
        res_ready = 1'b1;
        do_run(4, 3, ok);
        build_exp(4);
        n_checks++;
        if (!ok || got_q.size() != 4 || n_starts != 4) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d entries %0d starts want 4/4", got_q.size(), n_starts);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_errors++;
                $display("FAIL b2b_entry%0d: got %h want %h", i, g, exp_q[i]);
            end
        end
        n_checks++;
        if (min_gap != 5) begin
            n_errors++;
            $display("FAIL b2b_gap: got %0d want 5", min_gap);
        end
        n_checks++;
        if (run_min_dist !== exp_min || run_min_idx !== exp_min_idx) begin
            n_errors++;
            $display("FAIL b2b_min: got %0d@%0d want %0d@%0d", run_min_dist, run_min_idx,
                     exp_min, exp_min_idx);
        end
        fill_random(2);
        do_run(2, -1, ok);
        n_checks++;
        if (!ok || got_q.size() != 2 || n_done != 1) begin
            n_errors++;
            $display("FAIL b2b_second: got %0d entries %0d done want 2/1", got_q.size(), n_done);
        end
    endtask

    task automatic test_random();
        bit ok;
        int n;
        logic [DW-1:0] g;
        for (int it = 0; it < 4; it++) begin
            n       = int'($urandom_range(1, 7));
            m_hold  = int'($urandom_range(0, 3));
            m_delay = int'($urandom_range(1, 8));
            fill_random(n);
            rand_ready = 1'b1;
            do_run(n, -1, ok);
            #2;
            rand_ready = 1'b0;
            res_ready  = 1'b1;
            build_exp(n);
            n_checks++;
            if (!ok || got_q.size() != n || n_starts != n || n_done != 1) begin
                n_errors++;
                $display("FAIL rand%0d_count: got %0d entries %0d starts %0d done want %0d/%0d/1",
                         it, got_q.size(), n_starts, n_done, n, n);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                g = (i < got_q.size()) ? got_q[i] : 'x;
                n_checks++;
                if (g !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL rand%0d_entry%0d: got %h want %h", it, i, g, exp_q[i]);
                end
            end
            n_checks++;
            if (run_min_dist !== exp_min || run_min_idx !== exp_min_idx) begin
                n_errors++;
                $display("FAIL rand%0d_min: got %0d@%0d want %0d@%0d", it, run_min_dist,
                         run_min_idx, exp_min, exp_min_idx);
            end
            n_checks++;
            if (min_gap < 3 || unstable != 0) begin
                n_errors++;
                $display("FAIL rand%0d_timing: got gap=%0d unstable=%0d want >=3/0", it, min_gap,
                         unstable);
            end
        end
        m_hold = 1;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [DW-1:0] g;
        m_hold  = 1;
        m_delay = 3;
        fill_random(6);
        build_exp(6);
        clear_stats();
        res_ready = 1'b0;
        @(posedge clock);
        #1;
        num_blocks = IDX_W'(6);
        go         = 1'b1;
        @(posedge clock);
        #1;
        go = 1'b0;
        repeat (150) @(posedge clock);
        #1;
        n_checks++;
        if (n_starts != 4 || busy !== 1'b1 || res_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_hold: got starts=%0d busy=%b valid=%b want 4/1/1", n_starts, busy,
                     res_valid);
        end
        n_checks++;
        if (res_data !== exp_q[0]) begin
            n_errors++;
            $display("FAIL bp_head: got %h want %h", res_data, exp_q[0]);
        end
        res_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clock);
            #1;
            if (!busy && !res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (!ok || got_q.size() != 6 || n_starts != 6 || n_done != 1) begin
            n_errors++;
            $display("FAIL bp_count: got %0d entries %0d starts %0d done want 6/6/1",
                     got_q.size(), n_starts, n_done);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_errors++;
                $display("FAIL bp_entry%0d: got %h want %h", i, g, exp_q[i]);
            end
        end
        n_checks++;
        if (start_cyc.size() < 5 || pop_cyc.size() < 1 || start_cyc[4] <= pop_cyc[0] ||
            unstable != 0) begin
            n_errors++;
            $display("FAIL bp_order: got fifth start not after first pop or unstable=%0d",
                     unstable);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [DW-1:0] g;
        m_hold  = 1;
        m_delay = 4;
        m_never = 1;
        fill_random(3);
        m_dist[1] = 8'd0;
        res_ready = 1'b1;
        do_run(3, -1, ok);
        build_exp(3);
        n_checks++;
        if (!ok || got_q.size() != 3 || n_starts != 3) begin
            n_errors++;
            $display("FAIL tmo_count: got %0d entries %0d starts want 3/3", got_q.size(), n_starts);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_errors++;
                $display("FAIL tmo_entry%0d: got %h want %h", i, g, exp_q[i]);
            end
        end
        n_checks++;
        if (pop_cyc.size() < 2 || start_cyc.size() < 2 ||
            pop_cyc[1] - start_cyc[1] != int'(TIMEOUT)) begin
            n_errors++;
            $display("FAIL tmo_latency: got entry not %0d cycles after start", TIMEOUT);
        end
        n_checks++;
        if (run_min_dist !== exp_min || run_min_idx !== exp_min_idx) begin
            n_errors++;
            $display("FAIL tmo_min: got %0d@%0d want %0d@%0d", run_min_dist, run_min_idx,
                     exp_min, exp_min_idx);
        end
        m_never = -1;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        logic [DW-1:0] g;
        m_hold  = 1;
        m_delay = 10;
        fill_random(5);
        m_dist[0] = 8'd5;
        m_dist[1] = 8'd6;
        clear_stats();
        res_ready = 1'b0;
        @(posedge clock);
        #1;
        num_blocks = IDX_W'(5);
        go         = 1'b1;
        @(posedge clock);
        #1;
        go = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clock);
            #1;
            if (n_starts == 3) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (!ok || run_min_dist !== 8'd5) begin
            n_errors++;
            $display("FAIL rst_mid_pre: got ok=%0d min=%0d want 1/5", ok, run_min_dist);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        n_checks++;
        if ({res_valid, busy, me_start} !== 3'b000 || run_min_dist !== 8'hFF) begin
            n_errors++;
            $display("FAIL rst_mid_state: got vbs=%b min=%h want 000/ff",
                     {res_valid, busy, me_start}, run_min_dist);
        end
        repeat (30) @(posedge clock);
        #1;
        n_checks++;
        if (n_starts != 3 || res_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_quiet: got starts=%0d valid=%b want 3/0", n_starts, res_valid);
        end
        res_ready = 1'b1;
        fill_random(2);
        do_run(2, -1, ok);
        build_exp(2);
        n_checks++;
        if (!ok || got_q.size() != 2) begin
            n_errors++;
            $display("FAIL rst_mid_rerun: got %0d entries want 2", got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 'x;
            n_checks++;
            if (g !== exp_q[i]) begin
                n_errors++;
                $display("FAIL rst_mid_entry%0d: got %h want %h", i, g, exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_blocks();
        bit ok;
        res_ready = 1'b1;
        do_run(0, -1, ok);
        n_checks++;
        if (!ok || n_starts != 0 || n_done != 1) begin
            n_errors++;
            $display("FAIL zero_pulses: got starts=%0d done=%0d want 0/1", n_starts, n_done);
        end
        n_checks++;
        if (busy_seen != 0 || got_q.size() != 0) begin
            n_errors++;
            $display("FAIL zero_idle: got busy_cycles=%0d entries=%0d want 0/0", busy_seen,
                     got_q.size());
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_basic();
        test_stale_completed();
        test_back_to_back();
        test_random();
        test_backpressure();
        test_timeout();
        test_reset_mid_run();
        test_zero_blocks();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
